// File: rtl/low_to_high.sv
// Narrow-to-wide burst packer: gathers 2**BRUST_SIZE_LOG beats into one wide word and
// withholds the last beat's acknowledge until the wide sink has taken the word.
module low_to_high #(
  parameter int LOW_DATA_WIDTH = 32,
  parameter int BRUST_SIZE_LOG = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          low_read_valid,
  input  logic [LOW_DATA_WIDTH-1:0]                     low_read_data,
  output logic                                          low_read_finish,
  output logic                                          high_write_valid,
  output logic [LOW_DATA_WIDTH*(2**BRUST_SIZE_LOG)-1:0] high_write_data,
  input  logic                                          high_write_finish,
  output logic                                          protocol_err
);

  localparam int N      = 2 ** BRUST_SIZE_LOG;
  localparam int WORD_W = LOW_DATA_WIDTH * N;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  state_t                    state_p0, state_p1;
  logic [BRUST_SIZE_LOG-1:0] cnt_p0, cnt_p1;
  logic [WORD_W-1:0]         word_p0, word_p1;
  logic                      fin_p0, fin_p1;
  logic                      hwv_p0, hwv_p1;
  logic                      err_p0, err_p1;

  // p0: next-state decode from current state and handshake inputs
  always_comb begin
    state_p0 = state_p1;
    cnt_p0   = cnt_p1;
    word_p0  = word_p1;
    fin_p0   = 1'b0;
    hwv_p0   = 1'b0;
    err_p0   = err_p1;
    unique case (state_p1)
      COLLECT: begin
        if (low_read_valid) begin
          for (int i = 0; i < N; i++) begin
            if (cnt_p1 == BRUST_SIZE_LOG'(i))
              word_p0[i*LOW_DATA_WIDTH +: LOW_DATA_WIDTH] = low_read_data;
          end
          cnt_p0 = cnt_p1 + 1'b1;
          // The final beat is acknowledged later, once the wide word is consumed.
          if (cnt_p1 == BRUST_SIZE_LOG'(N - 1)) begin
            hwv_p0   = 1'b1;
            state_p0 = SEND;
          end else begin
            fin_p0 = 1'b1;
          end
        end
      end
      SEND: begin
        if (low_read_valid)
          err_p0 = 1'b1;
        if (high_write_finish) begin
          fin_p0   = 1'b1;
          state_p0 = COLLECT;
        end
      end
      default: state_p0 = COLLECT;
    endcase
  end

  // p1: registered state and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= COLLECT;
      cnt_p1   <= '0;
      word_p1  <= '0;
      fin_p1   <= 1'b0;
      hwv_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      cnt_p1   <= cnt_p0;
      word_p1  <= word_p0;
      fin_p1   <= fin_p0;
      hwv_p1   <= hwv_p0;
      err_p1   <= err_p0;
    end
  end

  assign low_read_finish  = fin_p1;
  assign high_write_valid = hwv_p1;
  assign high_write_data  = word_p1;
  assign protocol_err     = err_p1;

endmodule

// File: tb/tb_low_to_high.sv
// Directed bench for low_to_high (N=4, 32-bit beats): inputs driven on the falling edge,
// outputs checked on the following falling edge.
module tb_low_to_high;

  logic         clk;
  logic         rst_n;
  logic         low_read_valid;
  logic [31:0]  low_read_data;
  logic         low_read_finish;
  logic         high_write_valid;
  logic [127:0] high_write_data;
  logic         high_write_finish;
  logic         protocol_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fin_seen = 0;
  int hwv_seen = 0;

  low_to_high #(.LOW_DATA_WIDTH(32), .BRUST_SIZE_LOG(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .low_read_valid   (low_read_valid),
    .low_read_data    (low_read_data),
    .low_read_finish  (low_read_finish),
    .high_write_valid (high_write_valid),
    .high_write_data  (high_write_data),
    .high_write_finish(high_write_finish),
    .protocol_err     (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: each posedge sees the outputs of the cycle just ending.
  always @(posedge clk) begin
    if (low_read_finish)  fin_seen++;
    if (high_write_valid) hwv_seen++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [31:0] d);
    low_read_valid = 1'b1;
    low_read_data  = d;
    tick();
    low_read_valid = 1'b0;
  endtask

  // Sends four beats, then acknowledges the word in the same cycle it is presented.
  task automatic do_burst(input logic [31:0] b0, b1, b2, b3,
                          output logic hv, output logic [127:0] w, output logic fin);
    send_beat(b0);
    send_beat(b1);
    send_beat(b2);
    send_beat(b3);
    hv = high_write_valid;
    w  = high_write_data;
    high_write_finish = 1'b1;
    tick();
    high_write_finish = 1'b0;
    fin = low_read_finish;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk_cnt++;
    if (low_read_finish !== 1'b0) $display("FAIL reset_fin got=%b exp=0", low_read_finish);
    else pass_cnt++;
    chk_cnt++;
    if (high_write_valid !== 1'b0) $display("FAIL reset_hwv got=%b exp=0", high_write_valid);
    else pass_cnt++;
    chk_cnt++;
    if (high_write_data !== 128'h0) $display("FAIL reset_data got=%h exp=0", high_write_data);
    else pass_cnt++;
    chk_cnt++;
    if (protocol_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", protocol_err);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] beats [4];
    int f0, h0;
    beats = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    f0 = fin_seen;
    h0 = hwv_seen;
    for (int i = 0; i < 3; i++) begin
      send_beat(beats[i]);
      chk_cnt++;
      if (low_read_finish !== 1'b1 || high_write_valid !== 1'b0)
        $display("FAIL basic_beat%0d fin=%b hwv=%b exp fin=1 hwv=0", i, low_read_finish, high_write_valid);
      else pass_cnt++;
    end
    send_beat(beats[3]);
    chk_cnt++;
    if (high_write_valid !== 1'b1 || low_read_finish !== 1'b0)
      $display("FAIL basic_last hwv=%b fin=%b exp hwv=1 fin=0", high_write_valid, low_read_finish);
    else pass_cnt++;
    chk_cnt++;
    if (high_write_data !== 128'h44444444_33333333_22222222_11111111)
      $display("FAIL basic_data got=%h exp=44444444333333332222222211111111", high_write_data);
    else pass_cnt++;
    high_write_finish = 1'b1;
    tick();
    high_write_finish = 1'b0;
    chk_cnt++;
    if (low_read_finish !== 1'b1 || high_write_valid !== 1'b0)
      $display("FAIL basic_ack fin=%b hwv=%b exp fin=1 hwv=0", low_read_finish, high_write_valid);
    else pass_cnt++;
    tick();
    tick();
    chk_cnt++;
    if (fin_seen - f0 !== 4) $display("FAIL basic_fin_count got=%0d exp=4", fin_seen - f0);
    else pass_cnt++;
    chk_cnt++;
    if (hwv_seen - h0 !== 1) $display("FAIL basic_hwv_count got=%0d exp=1", hwv_seen - h0);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_w;
    exp_w = 128'h44444444_33333333_22222222_11111111;
    send_beat(32'h11111111);
    send_beat(32'h22222222);
    send_beat(32'h33333333);
    send_beat(32'h44444444);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_cnt++;
      if (low_read_finish !== 1'b0 || high_write_data !== exp_w)
        $display("FAIL hold_cyc%0d fin=%b data=%h exp fin=0 data=%h", c, low_read_finish, high_write_data, exp_w);
      else pass_cnt++;
    end
    high_write_finish = 1'b1;
    tick();
    high_write_finish = 1'b0;
    chk_cnt++;
    if (low_read_finish !== 1'b1) $display("FAIL hold_ack got=%b exp=1", low_read_finish);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (low_read_finish !== 1'b0) $display("FAIL hold_ack_once got=%b exp=0", low_read_finish);
    else pass_cnt++;
  endtask

  task automatic test_protocol_err();
    logic hv, fin;
    logic [127:0] w;
    logic [127:0] exp_w;
    exp_w = 128'h04040404_03030303_02020202_01010101;
    send_beat(32'h01010101);
    send_beat(32'h02020202);
    send_beat(32'h03030303);
    send_beat(32'h04040404);
    send_beat(32'hDEADBEEF);
    chk_cnt++;
    if (protocol_err !== 1'b1) $display("FAIL err_set got=%b exp=1", protocol_err);
    else pass_cnt++;
    chk_cnt++;
    if (high_write_data !== exp_w || low_read_finish !== 1'b0)
      $display("FAIL err_drop data=%h fin=%b exp data=%h fin=0", high_write_data, low_read_finish, exp_w);
    else pass_cnt++;
    high_write_finish = 1'b1;
    tick();
    high_write_finish = 1'b0;
    chk_cnt++;
    if (low_read_finish !== 1'b1) $display("FAIL err_ack got=%b exp=1", low_read_finish);
    else pass_cnt++;
    do_burst(32'h5, 32'h6, 32'h7, 32'h8, hv, w, fin);
    chk_cnt++;
    if (hv !== 1'b1 || w !== 128'h00000008_00000007_00000006_00000005 || fin !== 1'b1)
      $display("FAIL err_burst1 hv=%b data=%h fin=%b exp hv=1 data=00000008000000070000000600000005 fin=1", hv, w, fin);
    else pass_cnt++;
    do_burst(32'h9, 32'hA, 32'hB, 32'hC, hv, w, fin);
    chk_cnt++;
    if (hv !== 1'b1 || w !== 128'h0000000C_0000000B_0000000A_00000009 || fin !== 1'b1)
      $display("FAIL err_burst2 hv=%b data=%h fin=%b exp hv=1 data=0000000c0000000b0000000a00000009 fin=1", hv, w, fin);
    else pass_cnt++;
    chk_cnt++;
    if (protocol_err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", protocol_err);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic hv, fin;
    logic [127:0] w;
    send_beat(32'hEEEE0001);
    send_beat(32'hEEEE0002);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_cnt++;
    if (low_read_finish !== 1'b0 || high_write_valid !== 1'b0 || high_write_data !== 128'h0 || protocol_err !== 1'b0)
      $display("FAIL mrst_outputs fin=%b hwv=%b data=%h err=%b exp all 0",
               low_read_finish, high_write_valid, high_write_data, protocol_err);
    else pass_cnt++;
    tick();
    do_burst(32'hA, 32'hB, 32'hC, 32'hD, hv, w, fin);
    chk_cnt++;
    if (hv !== 1'b1 || w !== 128'h0000000D_0000000C_0000000B_0000000A || fin !== 1'b1)
      $display("FAIL mrst_burst hv=%b data=%h fin=%b exp hv=1 data=0000000d0000000c0000000b0000000a fin=1", hv, w, fin);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic hv1, fin1, hv2, fin2;
    logic [127:0] w1, w2;
    int f0, h0;
    tick();
    f0 = fin_seen;
    h0 = hwv_seen;
    do_burst(32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, hv1, w1, fin1);
    do_burst(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, hv2, w2, fin2);
    chk_cnt++;
    if (hv1 !== 1'b1 || w1 !== 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1 || fin1 !== 1'b1)
      $display("FAIL b2b_word1 hv=%b data=%h fin=%b exp hv=1 data=d4d4d4d4c3c3c3c3b2b2b2b2a1a1a1a1 fin=1", hv1, w1, fin1);
    else pass_cnt++;
    chk_cnt++;
    if (hv2 !== 1'b1 || w2 !== 128'h76543210_FEDCBA98_89ABCDEF_01234567 || fin2 !== 1'b1)
      $display("FAIL b2b_word2 hv=%b data=%h fin=%b exp hv=1 data=76543210fedcba9889abcdef01234567 fin=1", hv2, w2, fin2);
    else pass_cnt++;
    tick();
    tick();
    chk_cnt++;
    if (fin_seen - f0 !== 8 || hwv_seen - h0 !== 2)
      $display("FAIL b2b_counts fin=%0d hwv=%0d exp fin=8 hwv=2", fin_seen - f0, hwv_seen - h0);
    else pass_cnt++;
  endtask

  task automatic test_finish_in_collect();
    send_beat(32'h10000000);
    send_beat(32'h20000000);
    high_write_finish = 1'b1;
    tick();
    high_write_finish = 1'b0;
    chk_cnt++;
    if (low_read_finish !== 1'b0 || high_write_valid !== 1'b0)
      $display("FAIL stray_finish fin=%b hwv=%b exp fin=0 hwv=0", low_read_finish, high_write_valid);
    else pass_cnt++;
    send_beat(32'h30000000);
    chk_cnt++;
    if (low_read_finish !== 1'b1 || high_write_valid !== 1'b0)
      $display("FAIL stray_beat2 fin=%b hwv=%b exp fin=1 hwv=0", low_read_finish, high_write_valid);
    else pass_cnt++;
    send_beat(32'h40000000);
    chk_cnt++;
    if (high_write_valid !== 1'b1 || high_write_data !== 128'h40000000_30000000_20000000_10000000)
      $display("FAIL stray_word hwv=%b data=%h exp hwv=1 data=40000000300000002000000010000000",
               high_write_valid, high_write_data);
    else pass_cnt++;
    high_write_finish = 1'b1;
    tick();
    high_write_finish = 1'b0;
    chk_cnt++;
    if (low_read_finish !== 1'b1) $display("FAIL stray_ack got=%b exp=1", low_read_finish);
    else pass_cnt++;
  endtask

  initial begin
    rst_n             = 1'b0;
    low_read_valid    = 1'b0;
    low_read_data     = '0;
    high_write_finish = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_protocol_err();
    test_mid_reset();
    test_back_to_back();
    test_finish_in_collect();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
